// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// Each grant sends one byte. The arbiter launches the frame, waits for the UART
// to report busy, and releases the line when the frame ends.
//
// state     | meaning
// IDLE      | line free; arbitrate when any req is pending and the UART is idle
// LAUNCH    | single cycle: uart_enable and ack[grant_id] are high
// WAIT_BUSY | waiting for uart_busy to rise; times out after BUSY_TIMEOUT cycles
// WAIT_DONE | frame in flight; wait for uart_busy to fall
module uart_tx_arbiter #(
  parameter int N_REQ            = 4,
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int BUSY_TIMEOUT     = 16,
  localparam int DW = INPUT_DATA_WIDTH,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    ack,
  output logic                uart_enable,
  output logic [DW-1:0]       uart_data,
  input  logic                uart_busy,
  output logic [IW-1:0]       grant_id,
  output logic                active,
  output logic                timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   to_cnt;
  logic            win_found;
  logic [IW-1:0]   win_id;
  logic            grant_now;
  logic            timeout_hit;

  // Pick the first pending requester after the last winner, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = grant_id;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(grant_id) + i) % N_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = IW'(idx);
      end
    end
  end

  assign grant_now   = (state == IDLE) && win_found && !uart_busy;
  assign timeout_hit = (state == WAIT_BUSY) && !uart_busy &&
                       (to_cnt == CW'(BUSY_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (grant_now) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (uart_busy)        state_nxt = WAIT_DONE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      WAIT_DONE: if (!uart_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping, launched byte, busy-timeout counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_data   <= '0;
      grant_id    <= IW'(N_REQ - 1);
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (grant_now) begin
        uart_data <= req_data[int'(win_id)*DW +: DW];
        grant_id  <= win_id;
      end
      if (state == WAIT_BUSY && !uart_busy && !timeout_hit) to_cnt <= to_cnt + 1'b1;
      else                                                   to_cnt <= '0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

  // Enable and ack are decoded from the registered state so they drop with reset.
  always_comb begin
    uart_enable = (state == LAUNCH);
    ack         = '0;
    if (state == LAUNCH) ack[grant_id] = 1'b1;
    active      = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, round-robin, single request,
// busy timeout, foreign busy and reset in the middle of a frame.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        uart_enable;
  logic [7:0]  uart_data;
  logic        uart_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .uart_enable (uart_enable),
    .uart_data   (uart_data),
    .uart_busy   (uart_busy),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starting in IDLE with req pending: launch, see busy for busy_len cycles, return to IDLE.
  task automatic do_frame(input int id, input logic [7:0] byte_exp, input int busy_len,
                          input logic drop_req);
    tick();
    chk("launch_enable", 32'(uart_enable), 32'd1);
    chk("launch_ack",    32'(ack),         32'(4'b0001 << id));
    chk("launch_gid",    32'(grant_id),    32'(id));
    chk("launch_data",   32'(uart_data),   32'(byte_exp));
    if (drop_req) req = 4'b0000;
    tick();
    chk("wb_enable", 32'(uart_enable), 32'd0);
    chk("wb_ack",    32'(ack),         32'd0);
    uart_busy = 1'b1;
    for (int i = 0; i < busy_len; i++) begin
      tick();
      chk("busy_ack",    32'(ack),       32'd0);
      chk("busy_data",   32'(uart_data), 32'(byte_exp));
      chk("busy_active", 32'(active),    32'd1);
    end
    uart_busy = 1'b0;
    tick();
    chk("done_active", 32'(active),      32'd0);
    chk("done_enable", 32'(uart_enable), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req       = 4'hF;
    req_data  = 32'h44332211;
    uart_busy = 1'b0;

    // reset held 3 cycles with all requests pending
    repeat (3) tick();
    chk("rst_ack",    32'(ack),         32'd0);
    chk("rst_enable", 32'(uart_enable), 32'd0);
    chk("rst_data",   32'(uart_data),   32'd0);
    chk("rst_gid",    32'(grant_id),    32'd3);
    chk("rst_active", 32'(active),      32'd0);
    chk("rst_terr",   32'(timeout_err), 32'd0);
    rst_n = 1'b1;

    // round-robin: grant_id resets to 3, so order is 0,1,2,3,0
    do_frame(0, 8'h11, 4, 1'b0);
    do_frame(1, 8'h22, 5, 1'b0);
    do_frame(2, 8'h33, 3, 1'b0);
    do_frame(3, 8'h44, 6, 1'b0);
    do_frame(0, 8'h11, 2, 1'b1);
    tick();
    chk("rr_idle_active", 32'(active), 32'd0);

    // single requester 2 with byte A5
    req_data = 32'h00A50000;
    req      = 4'b0100;
    do_frame(2, 8'hA5, 10, 1'b1);

    // busy timeout: busy never rises
    req_data = 32'h0000BB55;
    req      = 4'b0001;
    tick();
    chk("to_enable", 32'(uart_enable), 32'd1);
    chk("to_ack",    32'(ack),         32'd1);
    req = 4'b0010;
    tick();
    chk("to_wb_active", 32'(active), 32'd1);
    repeat (15) tick();
    chk("to_pre_terr",   32'(timeout_err), 32'd0);
    chk("to_pre_active", 32'(active),      32'd1);
    tick();
    chk("to_terr",   32'(timeout_err), 32'd1);
    chk("to_active", 32'(active),      32'd0);
    do_frame(1, 8'hBB, 3, 1'b1);
    chk("to_terr_sticky", 32'(timeout_err), 32'd1);

    // foreign busy while idle: no grant until busy drops
    req_data  = 32'h0000C300;
    uart_busy = 1'b1;
    req       = 4'b0010;
    repeat (3) begin
      tick();
      chk("fb_enable", 32'(uart_enable), 32'd0);
      chk("fb_ack",    32'(ack),         32'd0);
      chk("fb_active", 32'(active),      32'd0);
    end
    uart_busy = 1'b0;
    do_frame(1, 8'hC3, 4, 1'b1);

    // reset asserted asynchronously in WAIT_DONE
    req_data = 32'hD7000000;
    req      = 4'b1000;
    tick();
    chk("mr_launch_ack", 32'(ack), 32'b1000);
    req = 4'b0000;
    tick();
    uart_busy = 1'b1;
    tick();
    chk("mr_wd_active", 32'(active), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_active", 32'(active),      32'd0);
    chk("mr_ack",    32'(ack),         32'd0);
    chk("mr_enable", 32'(uart_enable), 32'd0);
    chk("mr_data",   32'(uart_data),   32'd0);
    chk("mr_gid",    32'(grant_id),    32'd3);
    chk("mr_terr",   32'(timeout_err), 32'd0);
    uart_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      chk("mr_post_ack",    32'(ack),         32'd0);
      chk("mr_post_enable", 32'(uart_enable), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
